// File: rtl/pulse_sync_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pulse_sync_pkg: shared types and constants for the pulse spacer.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pulse_sync_pkg;

  typedef enum logic [0:0] {
    SP_IDLE = 1'b0,
    SP_GAP  = 1'b1
  } spacer_state_e;

  localparam int DROP_CNT_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/pulse_spacer_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter: up/down counter that never wraps; clear has priority.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;

  // Simultaneous inc and dec cancel, so the count holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !dec && !w_at_max) begin
      r_count <= r_count + C_ONE;
    end else if (dec && !inc && (r_count != '0)) begin
      r_count <= r_count - C_ONE;
    end
  end

  assign count  = r_count;
  assign at_max = w_at_max;

endmodule
`default_nettype wire

// File: rtl/pulse_spacer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pulse_spacer: buffers bursty event pulses and re-emits them spaced   |
// | MIN_GAP cycles apart. Optional macro PULSE_SPACER_STATS_EN adds a    |
// | clearable saturating drop counter.                                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pulse_spacer
  import pulse_sync_pkg::*;
#(
  parameter int MIN_GAP    = 4,
  parameter int PEND_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_pulse,
`ifdef PULSE_SPACER_STATS_EN
  input  logic                      stats_clr,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
`endif
  output logic                      out_pulse,
  output logic [PEND_WIDTH-1:0]     pending,
  output logic                      overflow,
  output logic                      busy
);

  localparam int                 GAP_W      = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0]   C_GAP_LOAD = GAP_W'(MIN_GAP - 1);
  localparam logic [GAP_W-1:0]   C_GAP_ONE  = GAP_W'(1);

  generate
    if (MIN_GAP < 2) begin : g_min_gap_check
      $error("pulse_spacer: MIN_GAP must be >= 2");
    end
  endgenerate

  spacer_state_e         r_state;
  spacer_state_e         w_state_nxt;
  logic [GAP_W-1:0]      r_gap;
  logic [GAP_W-1:0]      w_gap_nxt;
  logic                  r_out_pulse;
  logic                  r_overflow;
  logic                  w_emit;
  logic                  w_drop;
  logic                  w_pend_nz;
  logic                  w_pend_at_max;
  logic [PEND_WIDTH-1:0] w_pending;

  sat_counter #(
    .WIDTH (PEND_WIDTH)
  ) u_pend_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (in_pulse),
    .dec    (w_emit),
    .clr    (1'b0),
    .count  (w_pending),
    .at_max (w_pend_at_max)
  );

  assign w_pend_nz = (w_pending != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_emit      = 1'b0;
    case (r_state)
      SP_IDLE: begin
        if (w_pend_nz || in_pulse) begin
          w_emit      = 1'b1;
          w_state_nxt = SP_GAP;
          w_gap_nxt   = C_GAP_LOAD;
        end
      end
      SP_GAP: begin
        w_gap_nxt = r_gap - C_GAP_ONE;
        if (r_gap == C_GAP_ONE) begin
          w_state_nxt = SP_IDLE;
        end
      end
    endcase
  end

  // A launch frees a slot in the same edge, so a full counter still accepts.
  assign w_drop = in_pulse && w_pend_at_max && !w_emit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SP_IDLE;
      r_gap       <= '0;
      r_out_pulse <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gap       <= w_gap_nxt;
      r_out_pulse <= w_emit;
      r_overflow  <= w_drop;
    end
  end

`ifdef PULSE_SPACER_STATS_EN
  logic w_unused_drop_at_max;

  // Counts on the drop itself so drop_count moves on the same edge as overflow.
  sat_counter #(
    .WIDTH (DROP_CNT_WIDTH)
  ) u_drop_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (w_drop),
    .dec    (1'b0),
    .clr    (stats_clr),
    .count  (drop_count),
    .at_max (w_unused_drop_at_max)
  );
`endif

  assign out_pulse = r_out_pulse;
  assign overflow  = r_overflow;
  assign pending   = w_pending;
  assign busy      = w_pend_nz || (r_state == SP_GAP);

endmodule
`default_nettype wire

// File: tb/tb_pulse_spacer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pulse_spacer: directed self-checking bench for pulse_spacer.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pulse_spacer;
  import pulse_sync_pkg::*;

  localparam int MIN_GAP    = 4;
  localparam int PEND_WIDTH = 3;

  logic                  clk      = 1'b0;
  logic                  rst      = 1'b0;
  logic                  in_pulse = 1'b0;
  logic                  out_pulse;
  logic                  overflow;
  logic                  busy;
  logic [PEND_WIDTH-1:0] pending;
`ifdef PULSE_SPACER_STATS_EN
  logic                      stats_clr = 1'b0;
  logic [DROP_CNT_WIDTH-1:0] drop_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_out    = 0;
  int n_ovf    = 0;
  int max_pend = 0;

  always #5 clk = ~clk;

  pulse_spacer #(
    .MIN_GAP    (MIN_GAP),
    .PEND_WIDTH (PEND_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_pulse   (in_pulse),
`ifdef PULSE_SPACER_STATS_EN
    .stats_clr  (stats_clr),
    .drop_count (drop_count),
`endif
    .out_pulse  (out_pulse),
    .pending    (pending),
    .overflow   (overflow),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Drive in_pulse for the current cycle, then move to the next one.
  task automatic step(input logic inp);
    in_pulse = inp;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    in_pulse = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Asynchronous assertion before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_out", out_pulse, 0);
    check("rst_ovf", overflow, 0);
    check("rst_pend", pending, 0);
    check("rst_busy", busy, 0);

    // Single event
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      check("single_out", out_pulse, (cyc == 11));
      check("single_pend", pending, 0);
      if (cyc >= 11 && cyc <= 13) check("single_busy_hi", busy, 1);
      if (cyc <= 10 || cyc >= 15) check("single_busy_lo", busy, 0);
      step(cyc == 10);
    end

    // Burst of five
    do_reset();
    for (int i = 0; i <= 32; i++) begin
      check("burst_out", out_pulse, (cyc inside {11, 15, 19, 23, 27}));
      check("burst_ovf", overflow, 0);
      case (cyc)
        12:      check("burst_pend", pending, 1);
        14, 15:  check("burst_pend", pending, 3);
        19:      check("burst_pend", pending, 2);
        23:      check("burst_pend", pending, 1);
        27, 32:  check("burst_pend", pending, 0);
        default: ;
      endcase
      step(cyc >= 10 && cyc <= 14);
    end

    // Saturation: eleven back-to-back events into a 7-deep counter
    do_reset();
    n_out = 0; n_ovf = 0; max_pend = 0;
    for (int i = 0; i <= 55; i++) begin
      check("sat_out", out_pulse, (cyc >= 11 && cyc <= 47 && ((cyc - 11) % 4) == 0));
      check("sat_ovf", overflow, (cyc == 21));
      if (cyc == 21) check("sat_pend_full", pending, 7);
      if (cyc == 50) begin
        check("sat_pend_empty", pending, 0);
        check("sat_busy_end", busy, 0);
      end
      n_out += int'(out_pulse);
      n_ovf += int'(overflow);
      if (int'(pending) > max_pend) max_pend = int'(pending);
      step(cyc >= 10 && cyc <= 20);
    end
    check("sat_n_out", n_out, 10);
    check("sat_n_ovf", n_ovf, 1);
    check("sat_max_pend", max_pend, 7);

    // Event arriving on a launch edge with pending=2
    do_reset();
    for (int i = 0; i <= 24; i++) begin
      case (cyc)
        14:      check("simul_pend_before", pending, 2);
        15: begin
                 check("simul_pend_after", pending, 2);
                 check("simul_out", out_pulse, 1);
        end
        19:      check("simul_pend_19", pending, 1);
        23:      check("simul_pend_23", pending, 0);
        default: ;
      endcase
      step((cyc >= 10 && cyc <= 12) || cyc == 14);
    end

    // Reset while in GAP with pending=5
    do_reset();
    for (int i = 0; i < 17; i++) step(cyc >= 10 && cyc <= 16);
    check("midrst_pend_pre", pending, 5);
    check("midrst_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_pend", pending, 0);
    check("midrst_out", out_pulse, 0);
    check("midrst_ovf", overflow, 0);
    check("midrst_busy", busy, 0);
    do_reset();
    for (int i = 0; i <= 24; i++) begin
      check("midrst_post_out", out_pulse, (cyc == 21));
      check("midrst_post_pend", pending, 0);
      step(cyc == 20);
    end

`ifdef PULSE_SPACER_STATS_EN
    // Four drops; the clear lands on the fourth
    do_reset();
    for (int i = 0; i <= 28; i++) begin
      case (cyc)
        20:      check("stats_cnt_20", drop_count, 0);
        21:      check("stats_cnt_21", drop_count, 1);
        22:      check("stats_cnt_22", drop_count, 2);
        23:      check("stats_ovf_23", overflow, 0);
        24:      check("stats_cnt_24", drop_count, 3);
        25: begin
                 check("stats_cnt_clr", drop_count, 0);
                 check("stats_ovf_25", overflow, 1);
        end
        default: ;
      endcase
      stats_clr = (cyc == 24);
      step(cyc >= 10 && cyc <= 24);
    end
    stats_clr = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
